decompress_unpack: RTL and testbench

//  Inverse of the ML-KEM compress path: unpacks an LSB-first stream of d-bit fields into NUM_COEFFS 12-bit coefficients.

---
 rtl/decompress_unpack.sv | 154 +++++++++++++++
 tb/tb_decompress_unpack.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/decompress_unpack.sv
// rtl/decompress_unpack.sv - unpacks an LSB-first d-bit field stream into ML-KEM
// coefficients, applying Decompress_d on the way out.
module decompress_unpack #(
  parameter int IN_W          = 64,
  parameter int COEFF_PER_CYC = 4,
  parameter int NUM_COEFFS    = 256,
  parameter int BUF_W         = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        zeroize,
  input  logic                        start_i,
  input  logic [1:0]                  mode_i,
  input  logic                        in_valid_i,
  input  logic [IN_W-1:0]             in_data_i,
  output logic                        in_ready_o,
  output logic                        out_valid_o,
  output logic [COEFF_PER_CYC*12-1:0] out_data_o,
  input  logic                        out_ready_i,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int NUM_BEATS = NUM_COEFFS / COEFF_PER_CYC;
  localparam int FW        = $clog2(BUF_W + 1);
  localparam int CW        = $clog2(NUM_BEATS + 1);
  localparam int OW        = COEFF_PER_CYC * 12;
  localparam logic [11:0] MLKEM_Q = 12'd3329;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q;
  logic [3:0]       d_q;
  logic [FW-1:0]    fill_q;
  logic [BUF_W-1:0] bit_buf_q;
  logic [CW-1:0]    beat_cnt_q;
  logic [CW-1:0]    ext_cnt_q;
  logic             out_valid_q;
  logic [OW-1:0]    out_data_q;

  logic [FW-1:0]    step;
  logic             accept;
  logic             extract;
  logic             out_hs;
  logic [BUF_W-1:0] buf_sh;
  logic [BUF_W-1:0] buf_nx;
  logic [FW-1:0]    fill_sh;
  logic [FW-1:0]    fill_nx;
  logic [OW-1:0]    coeff_nx;
  logic [BUF_W-1:0] field_sh;
  logic [11:0]      field;
  logic [11:0]      field_mask;
  logic [FW-1:0]    field_off;

  function automatic logic [11:0] decompress(input logic [11:0] x, input logic [3:0] d);
    logic [23:0] p;
    logic [23:0] r;
    p = 24'(x) * 24'(MLKEM_Q) + (24'd1 << (d - 4'd1));
    r = p >> d;
    return (d == 4'd12) ? x : r[11:0];
  endfunction

  assign step   = FW'(COEFF_PER_CYC) * FW'(d_q);
  assign out_hs = out_valid_q & out_ready_i;

  // Readiness depends only on registered fill so the consumer never sees a comb loop.
  assign in_ready_o = (state_q == S_RUN) &&
                      (({1'b0, fill_q} + (FW+1)'(IN_W)) <= (FW+1)'(BUF_W));
  assign accept     = in_valid_i & in_ready_o;
  assign extract    = (state_q == S_RUN) && (fill_q >= step) &&
                      (ext_cnt_q < CW'(NUM_BEATS)) && (!out_valid_q || out_ready_i);

  always_comb begin
    buf_sh  = extract ? (bit_buf_q >> step) : bit_buf_q;
    fill_sh = extract ? (fill_q - step) : fill_q;
    buf_nx  = buf_sh;
    fill_nx = fill_sh;
    if (accept) begin
      buf_nx  = buf_sh | ({{(BUF_W-IN_W){1'b0}}, in_data_i} << fill_sh);
      fill_nx = fill_sh + FW'(IN_W);
    end
  end

  // Field k sits at bit k*d of the buffer; mask trick yields 12'hFFF for d=12.
  always_comb begin
    coeff_nx   = '0;
    field_sh   = '0;
    field      = '0;
    field_off  = '0;
    field_mask = 12'((13'd1 << d_q) - 13'd1);
    for (int k = 0; k < COEFF_PER_CYC; k++) begin
      field_off = FW'(k) * FW'(d_q);
      field_sh  = bit_buf_q >> field_off;
      field     = field_sh[11:0] & field_mask;
      coeff_nx[12*k +: 12] = decompress(field, d_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || zeroize) begin
      state_q     <= S_IDLE;
      d_q         <= 4'd1;
      fill_q      <= '0;
      bit_buf_q   <= '0;
      beat_cnt_q  <= '0;
      ext_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_RUN;
            fill_q     <= '0;
            bit_buf_q  <= '0;
            beat_cnt_q <= '0;
            ext_cnt_q  <= '0;
            case (mode_i)
              2'd0:    d_q <= 4'd1;
              2'd1:    d_q <= 4'd5;
              2'd2:    d_q <= 4'd11;
              default: d_q <= 4'd12;
            endcase
          end
        end
        S_RUN: begin
          bit_buf_q <= buf_nx;
          fill_q    <= fill_nx;
          if (extract) begin
            out_valid_q <= 1'b1;
            out_data_q  <= coeff_nx;
            ext_cnt_q   <= ext_cnt_q + 1'b1;
          end else if (out_hs) begin
            out_valid_q <= 1'b0;
          end
          if (out_hs) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == CW'(NUM_BEATS - 1)) state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = (state_q == S_RUN);
  assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_decompress_unpack.sv
// tb/tb_decompress_unpack.sv - table vectors, random streams vs. bit-level model,
// stall/reset corner cases for decompress_unpack.
module tb_decompress_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        zeroize;
  logic        start_i;
  logic [1:0]  mode_i;
  logic        in_valid_i;
  logic [63:0] in_data_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic [47:0] out_data_o;
  logic        out_ready_i;
  logic        busy_o;
  logic        done_o;

  always #5 clk = ~clk;

  decompress_unpack dut (
    .clk(clk), .rst(rst), .zeroize(zeroize), .start_i(start_i), .mode_i(mode_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  int          total  = 0;
  int          passed = 0;
  logic [63:0] words[48];
  int          got[256];
  int          beats;
  bit          ab;

  typedef struct {
    int          mode;
    logic [63:0] w0;
    logic [63:0] w1;
    logic [63:0] wr;
    int          idx;
    int          exp;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int dval(input int mode);
    case (mode)
      0:       return 1;
      1:       return 5;
      2:       return 11;
      default: return 12;
    endcase
  endfunction

  // Coefficient i taken straight from the bit stream with plain integer rounding.
  function automatic int model(input int mode, input int i);
    int d = dval(mode);
    int x = 0;
    for (int j = 0; j < d; j++) begin
      int p = i * d + j;
      if (words[p / 64][p % 64]) x += (1 << j);
    end
    if (d == 12) return x;
    return (x * 3329 + 2 ** (d - 1)) / (2 ** d);
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready_o, 0);
    chk({tag, "_out_valid"}, out_valid_o, 0);
    chk({tag, "_out_data"}, out_data_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  task automatic run_poly(input int mode, input int vprob, input int rprob,
                          input int abort_at, output bit aborted);
    int          nw        = 4 * dval(mode);
    int          widx      = 0;
    int          last_hs   = -10;
    int          stall_err = 0;
    int          errs      = 0;
    bit          pv        = 0;
    bit          pr        = 0;
    logic [47:0] pd        = '0;
    bit          done_seen = 0;
    aborted = 0;
    beats   = 0;
    @(negedge clk);
    start_i = 1'b1;
    mode_i  = 2'(mode);
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1);
    for (int c = 0; c < 3000; c++) begin
      if (pv && !pr && (!out_valid_o || out_data_o !== pd)) stall_err++;
      if (done_o) begin
        done_seen = 1;
        chk("done_one_after_last_hs", c - last_hs, 1);
        break;
      end
      if (abort_at >= 0 && beats == abort_at) begin
        aborted = 1;
        break;
      end
      in_valid_i  = (widx < nw) && ($urandom_range(99) < vprob);
      in_data_i   = in_valid_i ? words[widx] : {$urandom, $urandom};
      out_ready_i = ($urandom_range(99) < rprob);
      start_i     = 1'($urandom_range(1));
      mode_i      = 2'($urandom);
      if (in_valid_i && in_ready_o) widx++;
      if (out_valid_o && out_ready_i) begin
        if (beats < 64)
          for (int k = 0; k < 4; k++) got[beats * 4 + k] = int'(out_data_o[12 * k +: 12]);
        beats++;
        last_hs = c;
      end
      pv = out_valid_o;
      pr = out_ready_i;
      pd = out_data_o;
      @(negedge clk);
    end
    start_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    if (!aborted) begin
      chk("done_seen", done_seen, 1);
      chk("beat_count", beats, 64);
      chk("words_accepted", widx, nw);
      chk("stall_data_stable", stall_err, 0);
      for (int i = 0; i < 256; i++) if (got[i] != model(mode, i)) errs++;
      chk($sformatf("coeffs_vs_model_mode%0d", mode), errs, 0);
      @(negedge clk);
      chk("done_single_cycle", done_o, 0);
      chk("idle_after_done", busy_o, 0);
    end
  endtask

  task automatic fill_random();
    for (int w = 0; w < 48; w++) words[w] = {$urandom, $urandom};
  endtask

  initial begin
    vecs[0]  = '{0, 64'h1, 64'h0, 64'h0, 0, 1665};
    vecs[1]  = '{0, 64'h1, 64'h0, 64'h0, 1, 0};
    vecs[2]  = '{0, '1, '1, '1, 255, 1665};
    vecs[3]  = '{1, 64'h1F, 64'h0, 64'h0, 0, 3225};
    vecs[4]  = '{1, '1, '1, '1, 200, 3225};
    vecs[5]  = '{1, 64'h20, 64'h0, 64'h0, 1, 104};
    vecs[6]  = '{2, 64'h7FF, 64'h0, 64'h0, 0, 3327};
    vecs[7]  = '{2, 64'h1, 64'h0, 64'h0, 0, 2};
    vecs[8]  = '{2, 64'hFF80_0000_0000_0000, 64'h3, 64'h0, 5, 3327};
    vecs[9]  = '{2, 64'hFF80_0000_0000_0000, 64'h3, 64'h0, 4, 0};
    vecs[10] = '{3, 64'hD00, 64'h0, 64'h0, 0, 'hD00};
    vecs[11] = '{3, '1, '1, '1, 255, 4095};
    vecs[12] = '{3, 64'hA000_0000_0000_0000, 64'hBC, 64'h0, 5, 'hBCA};

    rst = 1'b1; zeroize = 1'b0; start_i = 1'b0; mode_i = 2'd0;
    in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      words[0] = vecs[i].w0;
      words[1] = vecs[i].w1;
      for (int w = 2; w < 48; w++) words[w] = vecs[i].wr;
      run_poly(vecs[i].mode, 100, 100, -1, ab);
      chk($sformatf("vec%0d_coeff%0d", i, vecs[i].idx), got[vecs[i].idx], vecs[i].exp);
    end

    for (int m = 0; m < 4; m++) begin
      fill_random();
      run_poly(m, 65, 55, -1, ab);
    end

    for (int r = 0; r < 2; r++) begin
      fill_random();
      run_poly(2, 80, 70, 30, ab);
      chk("abort_reached_beat30", ab, 1);
      if (r == 0) rst = 1'b1;
      else zeroize = 1'b1;
      @(negedge clk);
      check_outputs_zero(r == 0 ? "mid_rst" : "mid_zeroize");
      rst = 1'b0;
      zeroize = 1'b0;
      fill_random();
      run_poly(r == 0 ? 1 : 3, 75, 60, -1, ab);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
